// File: rtl/jtcop_vram_arb.sv
// Bank-0 SDRAM arbiter for the three BAC06 tilemap VRAM read ports and the CPU VRAM write path.
// Each read port keeps a one-word cache; CPU writes win, reads are served round-robin.
module jtcop_vram_arb #(
   parameter logic [21:0] B0_OFS = 22'h00000,
   parameter logic [21:0] B1_OFS = 22'h02000,
   parameter logic [21:0] B2_OFS = 22'h02800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        b0_cs,
   input  logic [12:0] b0_addr,
   output logic [15:0] b0_data,
   output logic        b0_ok,
   input  logic        b1_cs,
   input  logic [10:0] b1_addr,
   output logic [15:0] b1_data,
   output logic        b1_ok,
   input  logic        b2_cs,
   input  logic [10:0] b2_addr,
   output logic [15:0] b2_data,
   output logic        b2_ok,
   input  logic        cpu_cs,
   input  logic [1:0]  cpu_rgn,
   input  logic [12:0] cpu_addr,
   input  logic [15:0] cpu_din,
   input  logic [1:0]  cpu_dsn,
   output logic        cpu_ok,
   output logic [21:0] ba_addr,
   output logic        ba_rd,
   output logic        ba_wr,
   output logic [15:0] ba_din,
   output logic [1:0]  ba_din_m,
   input  logic        ba_ack,
   input  logic        ba_rdy,
   input  logic [15:0] data_read,
   output logic [1:0]  fsm_st
);

   // Bank handshake: ba_rd/ba_wr is held until ba_ack is sampled high and dropped on
   // that same edge; ba_rdy then closes the access (it may coincide with ba_ack).
   typedef enum logic [1:0] { ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2 } st_t;

   localparam logic [1:0] GNT_CPU = 2'd3;

   st_t         st;
   logic [1:0]  gnt;
   logic [1:0]  rr;
   logic [12:0] gnt_addr;
   logic [1:0]  wr_rgn;
   logic [12:0] wr_addr;
   logic        cpu_done;

   logic [2:0]  valid, valid_n;
   logic [12:0] lat0, lat0_n;
   logic [10:0] lat1, lat1_n, lat2, lat2_n;

   logic [2:0]  need;
   logic        cpu_req;
   logic [1:0]  pick;
   logic [21:0] rd_addr, wr_bank_addr;
   logic [12:0] rd_gaddr;
   logic        done, rd_done, wr_done;

   assign fsm_st  = st;
   assign cpu_req = cpu_cs & ~cpu_done;
   assign need[0] = b0_cs & (~valid[0] | (b0_addr != lat0));
   assign need[1] = b1_cs & (~valid[1] | (b1_addr != lat1));
   assign need[2] = b2_cs & (~valid[2] | (b2_addr != lat2));

   assign done    = ((st == ST_REQ) & ba_ack & ba_rdy) | ((st == ST_WAIT) & ba_rdy);
   assign rd_done = done & (gnt != GNT_CPU);
   assign wr_done = done & (gnt == GNT_CPU);

   // Round-robin: rr names the port with highest priority on the next read grant
   always_comb begin
      pick = 2'd0;
      case (rr)
         2'd1:    pick = need[1] ? 2'd1 : (need[2] ? 2'd2 : 2'd0);
         2'd2:    pick = need[2] ? 2'd2 : (need[0] ? 2'd0 : 2'd1);
         default: pick = need[0] ? 2'd0 : (need[1] ? 2'd1 : 2'd2);
      endcase
   end

   always_comb begin
      rd_addr  = 22'd0;
      rd_gaddr = 13'd0;
      case (pick)
         2'd0: begin
            rd_addr  = B0_OFS + {9'd0, b0_addr};
            rd_gaddr = b0_addr;
         end
         2'd1: begin
            rd_addr  = B1_OFS + {11'd0, b1_addr};
            rd_gaddr = {2'd0, b1_addr};
         end
         default: begin
            rd_addr  = B2_OFS + {11'd0, b2_addr};
            rd_gaddr = {2'd0, b2_addr};
         end
      endcase
   end

   always_comb begin
      wr_bank_addr = 22'd0;
      case (cpu_rgn)
         2'd0:    wr_bank_addr = B0_OFS + {9'd0, cpu_addr};
         2'd1:    wr_bank_addr = B1_OFS + {11'd0, cpu_addr[10:0]};
         2'd2:    wr_bank_addr = B2_OFS + {11'd0, cpu_addr[10:0]};
         default: wr_bank_addr = 22'd0;
      endcase
   end

   // Cache state after this edge: read fills first, then a finishing CPU write
   // knocks out any entry holding the address it just overwrote.
   always_comb begin
      valid_n = valid;
      lat0_n  = lat0;
      lat1_n  = lat1;
      lat2_n  = lat2;
      if (rd_done) begin
         case (gnt)
            2'd0: begin valid_n[0] = 1'b1; lat0_n = gnt_addr;       end
            2'd1: begin valid_n[1] = 1'b1; lat1_n = gnt_addr[10:0]; end
            2'd2: begin valid_n[2] = 1'b1; lat2_n = gnt_addr[10:0]; end
            default: ;
         endcase
      end
      if (wr_done) begin
         if (wr_rgn == 2'd0 && lat0_n == wr_addr)        valid_n[0] = 1'b0;
         if (wr_rgn == 2'd1 && lat1_n == wr_addr[10:0])  valid_n[1] = 1'b0;
         if (wr_rgn == 2'd2 && lat2_n == wr_addr[10:0])  valid_n[2] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= ST_IDLE;
         gnt      <= 2'd0;
         rr       <= 2'd0;
         gnt_addr <= 13'd0;
         wr_rgn   <= 2'd0;
         wr_addr  <= 13'd0;
         cpu_done <= 1'b0;
         valid    <= 3'd0;
         lat0     <= 13'd0;
         lat1     <= 11'd0;
         lat2     <= 11'd0;
         b0_data  <= 16'd0;
         b1_data  <= 16'd0;
         b2_data  <= 16'd0;
         b0_ok    <= 1'b0;
         b1_ok    <= 1'b0;
         b2_ok    <= 1'b0;
         cpu_ok   <= 1'b0;
         ba_addr  <= 22'd0;
         ba_rd    <= 1'b0;
         ba_wr    <= 1'b0;
         ba_din   <= 16'd0;
         ba_din_m <= 2'b11;
      end else begin
         cpu_ok <= 1'b0;
         valid  <= valid_n;
         lat0   <= lat0_n;
         lat1   <= lat1_n;
         lat2   <= lat2_n;
         b0_ok  <= valid_n[0] & b0_cs & (b0_addr == lat0_n);
         b1_ok  <= valid_n[1] & b1_cs & (b1_addr == lat1_n);
         b2_ok  <= valid_n[2] & b2_cs & (b2_addr == lat2_n);
         // A held cpu_cs must go low once before another write is accepted
         if (!cpu_cs) cpu_done <= 1'b0;

         case (st)
            ST_IDLE: begin
               if (cpu_req) begin
                  if (cpu_rgn == 2'd3) begin
                     cpu_ok   <= 1'b1;
                     cpu_done <= 1'b1;
                  end else begin
                     gnt      <= GNT_CPU;
                     wr_rgn   <= cpu_rgn;
                     wr_addr  <= cpu_addr;
                     ba_addr  <= wr_bank_addr;
                     ba_din   <= cpu_din;
                     ba_din_m <= cpu_dsn;
                     ba_wr    <= 1'b1;
                     st       <= ST_REQ;
                  end
               end else if (|need) begin
                  gnt      <= pick;
                  gnt_addr <= rd_gaddr;
                  ba_addr  <= rd_addr;
                  ba_rd    <= 1'b1;
                  rr       <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                  st       <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (ba_ack) begin
                  ba_rd <= 1'b0;
                  ba_wr <= 1'b0;
                  st    <= ba_rdy ? ST_IDLE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (ba_rdy) st <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase

         if (rd_done) begin
            case (gnt)
               2'd0:    b0_data <= data_read;
               2'd1:    b1_data <= data_read;
               2'd2:    b2_data <= data_read;
               default: ;
            endcase
         end
         if (wr_done) begin
            cpu_ok   <= 1'b1;
            cpu_done <= 1'b1;
         end
      end
   end

endmodule
